// File: rtl/serdesphy_pcs_tx_lane_v2_if.sv
// Word-side write handshake and serial-side output bundle of the PCS TX lane.
interface serdesphy_pcs_tx_lane_v2_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_serial_data;
  logic              tx_serial_valid;
  logic              tx_idle_pattern;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_serial_data, tx_serial_valid, tx_idle_pattern
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_serial_data, tx_serial_valid, tx_idle_pattern
  );
endinterface

// File: rtl/serdesphy_pcs_tx_lane_v2.sv
// PCS transmit lane: word FIFO, FIFO/PRBS/idle source selection on word
// boundaries, LSB-first serialiser and sticky FIFO status.
module serdesphy_pcs_tx_lane_v2 #(
  parameter int                DATA_W     = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(4'b1010),
  parameter int                LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 tx_fifo_en,
  input  logic                 tx_prbs_en,
  input  logic                 tx_idle,
  input  logic                 tx_data_sel,
  input  logic                 prbs_sel,
  input  logic                 sticky_clr,
  serdesphy_pcs_tx_lane_v2_if.slave bus,
  output logic                 tx_fifo_full,
  output logic                 tx_fifo_empty,
  output logic                 tx_overflow,
  output logic                 tx_underflow,
  output logic                 tx_active,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_IDLE,
    ST_DATA,
    ST_PRBS
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [6:0]        lfsr7_q, lfsr7_d;
  logic [14:0]       lfsr15_q, lfsr15_d;
  logic              prbs15_q, prbs15_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_valid_q, ser_valid_d;
  logic              idle_pat_q, idle_pat_d;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q, unf_q;

  logic              boundary, word_load, data_load;
  logic              fifo_full, fifo_empty;
  logic              push, pop, ovf_evt, unf_evt;
  logic              prbs_entry, use15, prbs_bit;
  logic [6:0]        lfsr7_src;
  logic [14:0]       lfsr15_src;
  logic [DATA_W-1:0] load_word;

  assign fifo_full  = (level_q == FULL_LVL);
  assign fifo_empty = (level_q == '0);

  // OFF has no word in flight, so every OFF cycle is a boundary.
  assign boundary = (state_q == ST_OFF) || (bit_cnt_q == LAST_BIT);

  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    if (!tx_en) begin
      state_d = ST_OFF;
    end else if (boundary) begin
      if (tx_idle)                        state_d = ST_IDLE;
      else if (tx_data_sel && tx_prbs_en) state_d = ST_PRBS;
      else if (tx_fifo_en)                state_d = ST_DATA;
      else                                state_d = ST_IDLE;
    end
  end

  assign word_load = boundary && tx_en;
  assign data_load = word_load && (state_d == ST_DATA);
  assign pop       = data_load && !fifo_empty;
  assign unf_evt   = data_load && fifo_empty;
  assign push      = bus.tx_valid && tx_fifo_en && (!fifo_full || pop);
  assign ovf_evt   = bus.tx_valid && tx_fifo_en && fifo_full && !pop;

  assign load_word = pop ? mem[rd_ptr_q] : IDLE_WORD;

  // Entry into PRBS re-seeds and latches the polynomial choice for the run.
  assign prbs_entry = (state_d == ST_PRBS) && (state_q != ST_PRBS);
  assign use15      = prbs_entry ? prbs_sel : prbs15_q;
  assign lfsr7_src  = prbs_entry ? '1 : lfsr7_q;
  assign lfsr15_src = prbs_entry ? '1 : lfsr15_q;
  assign prbs_bit   = use15 ? (lfsr15_src[14] ^ lfsr15_src[13])
                            : (lfsr7_src[6] ^ lfsr7_src[5]);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    lfsr7_d     = lfsr7_q;
    lfsr15_d    = lfsr15_q;
    prbs15_d    = prbs15_q;
    ser_data_d  = 1'b0;
    ser_valid_d = 1'b0;
    idle_pat_d  = 1'b0;
    if (state_d == ST_OFF) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else begin
      ser_valid_d = 1'b1;
      bit_cnt_d   = word_load ? '0 : bit_cnt_q + 1'b1;
      if (state_d == ST_PRBS) begin
        ser_data_d = prbs_bit;
        prbs15_d   = use15;
        lfsr7_d    = lfsr7_src;
        lfsr15_d   = lfsr15_src;
        if (use15) lfsr15_d = {lfsr15_src[13:0], prbs_bit};
        else       lfsr7_d  = {lfsr7_src[5:0], prbs_bit};
        if (word_load) shreg_d = '0;
      end else if (word_load) begin
        // First bit of the new word goes out on the same edge it is loaded.
        shreg_d    = load_word;
        ser_data_d = load_word[0];
        idle_pat_d = (state_d == ST_IDLE) || unf_evt;
      end else begin
        ser_data_d = shreg_q[bit_cnt_d];
        idle_pat_d = idle_pat_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      lfsr7_q     <= '1;
      lfsr15_q    <= '1;
      prbs15_q    <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      idle_pat_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      lfsr7_q     <= lfsr7_d;
      lfsr15_q    <= lfsr15_d;
      prbs15_q    <= prbs15_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      idle_pat_q  <= idle_pat_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the level/pointers alone decide
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst || !tx_fifo_en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  // A set event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt || (ovf_q && !sticky_clr);
      unf_q <= unf_evt || (unf_q && !sticky_clr);
    end
  end

  assign bus.tx_ready        = !fifo_full;
  assign bus.tx_serial_data  = ser_data_q;
  assign bus.tx_serial_valid = ser_valid_q;
  assign bus.tx_idle_pattern = idle_pat_q;
  assign tx_fifo_full        = fifo_full;
  assign tx_fifo_empty       = fifo_empty;
  assign tx_overflow         = ovf_q;
  assign tx_underflow        = unf_q;
  assign tx_active           = (state_q == ST_DATA) || (state_q == ST_PRBS);
  assign fifo_level          = level_q;

endmodule

// File: tb/tb_serdesphy_pcs_tx_lane_v2.sv
// Scoreboard bench for the PCS TX lane: stimulus queues expected serial bits,
// a negedge monitor pops and compares every valid serial bit.
module tb_serdesphy_pcs_tx_lane_v2;
  localparam int DATA_W     = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = 4;
  localparam logic [DATA_W-1:0] IDLE_W = 4'b1010;

  typedef struct packed {
    logic data;
    logic idle;
  } exp_t;

  logic clk = 1'b0;
  logic rst, tx_en, tx_fifo_en, tx_prbs_en, tx_idle, tx_data_sel, prbs_sel, sticky_clr;
  logic tx_fifo_full, tx_fifo_empty, tx_overflow, tx_underflow, tx_active;
  logic [LVL_W-1:0] fifo_level;

  serdesphy_pcs_tx_lane_v2_if #(.DATA_W(DATA_W)) bus ();

  serdesphy_pcs_tx_lane_v2 #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .IDLE_WORD(IDLE_W), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_fifo_en(tx_fifo_en),
    .tx_prbs_en(tx_prbs_en), .tx_idle(tx_idle), .tx_data_sel(tx_data_sel),
    .prbs_sel(prbs_sel), .sticky_clr(sticky_clr), .bus(bus),
    .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .tx_overflow(tx_overflow), .tx_underflow(tx_underflow),
    .tx_active(tx_active), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  bit [6:0]  m7;
  bit [14:0] m15;
  bit        p7[127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_bit(input logic d, input logic idle);
    exp_t e;
    e.data = d;
    e.idle = idle;
    sb.push_back(e);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w, input logic idle, input int nbits);
    for (int i = 0; i < nbits; i++) push_bit(w[i], idle);
  endtask

  function automatic bit prbs7_step();
    bit n;
    n  = m7[6] ^ m7[5];
    m7 = {m7[5:0], n};
    return n;
  endfunction

  function automatic bit prbs15_step();
    bit n;
    n   = m15[14] ^ m15[13];
    m15 = {m15[13:0], n};
    return n;
  endfunction

  task automatic write_word(input logic [DATA_W-1:0] w);
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
  endtask

  // Monitor: every valid serial bit must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_serial_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("serial_unexpected", {31'd0, bus.tx_serial_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("serial", {30'd0, bus.tx_serial_data, bus.tx_idle_pattern}, {30'd0, e.data, e.idle});
        end
      end
    end
  end

  initial begin
    bit [7:0] first8;
    rst = 1'b1; tx_en = 0; tx_fifo_en = 0; tx_prbs_en = 0; tx_idle = 0;
    tx_data_sel = 0; prbs_sel = 0; sticky_clr = 0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_serial_data", bus.tx_serial_data, 0);
    check("rst_serial_valid", bus.tx_serial_valid, 0);
    check("rst_idle_pattern", bus.tx_idle_pattern, 0);
    check("rst_active", tx_active, 0);
    check("rst_overflow", tx_overflow, 0);
    check("rst_underflow", tx_underflow, 0);
    check("rst_empty", tx_fifo_empty, 1);
    check("rst_full", tx_fifo_full, 0);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_level", fifo_level, 0);

    // Idle pattern straight out of OFF
    push_word(IDLE_W, 1'b1, 4);
    push_word(IDLE_W, 1'b1, 4);
    tx_en = 1'b1; tx_idle = 1'b1;
    step(8);
    check("idle_active", tx_active, 0);
    tx_en = 1'b0; tx_idle = 1'b0;
    step(1);
    check("idle_off_valid", bus.tx_serial_valid, 0);
    check("idle_sb_drained", sb.size(), 0);

    // FIFO data then underflow
    tx_fifo_en = 1'b1;
    write_word(4'h3);
    write_word(4'hC);
    check("data_level2", fifo_level, 2);
    check("data_not_empty", tx_fifo_empty, 0);
    push_word(4'h3, 1'b0, 4);
    push_word(4'hC, 1'b0, 4);
    push_word(IDLE_W, 1'b1, 4);
    tx_en = 1'b1;
    step(1);
    check("data_level1", fifo_level, 1);
    check("data_active", tx_active, 1);
    check("data_no_underflow", tx_underflow, 0);
    step(3);
    check("data_level1_hold", fifo_level, 1);
    step(1);
    check("data_level0", fifo_level, 0);
    step(3);
    step(1);
    check("underflow_set", tx_underflow, 1);
    check("underflow_idle_pat", bus.tx_idle_pattern, 1);
    check("underflow_still_data", tx_active, 1);
    step(3);
    tx_en = 1'b0;
    step(1);
    check("data_off_valid", bus.tx_serial_valid, 0);
    check("data_sb_drained", sb.size(), 0);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    check("underflow_cleared", tx_underflow, 0);

    // Overflow: nine writes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) write_word(DATA_W'(i + 1));
    check("ovf_level", fifo_level, 8);
    check("ovf_full", tx_fifo_full, 1);
    check("ovf_ready", bus.tx_ready, 0);
    check("ovf_set", tx_overflow, 1);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    check("ovf_cleared", tx_overflow, 0);
    sticky_clr = 1'b1;
    write_word(4'hF);
    sticky_clr = 1'b0;
    check("ovf_set_wins", tx_overflow, 1);
    check("ovf_level_hold", fifo_level, 8);
    sticky_clr = 1'b1;
    step(1);
    sticky_clr = 1'b0;
    check("ovf_cleared2", tx_overflow, 0);

    // Full FIFO: pop at boundary plus simultaneous write is accepted
    for (int i = 0; i < 8; i++) push_word(DATA_W'(i + 1), 1'b0, 4);
    push_word(4'hE, 1'b0, 4);
    tx_en = 1'b1;
    bus.tx_data = 4'hE; bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
    check("fullpop_level", fifo_level, 8);
    check("fullpop_no_ovf", tx_overflow, 0);
    step(35);
    tx_en = 1'b0;
    step(1);
    check("fullpop_level0", fifo_level, 0);
    check("fullpop_no_underflow", tx_underflow, 0);
    check("fullpop_sb_drained", sb.size(), 0);

    // PRBS7: hand-checked prefix, then period-127 repeat, exit on boundary
    tx_fifo_en = 1'b0;
    m7 = '1;
    for (int i = 0; i < 127; i++) p7[i] = prbs7_step();
    first8 = 8'b0100_0000;
    for (int i = 0; i < 8; i++) push_bit(first8[i], 1'b0);
    for (int i = 8; i < 132; i++) push_bit(p7[i % 127], 1'b0);
    push_word(IDLE_W, 1'b1, 4);
    tx_prbs_en = 1'b1; tx_data_sel = 1'b1; prbs_sel = 1'b0; tx_en = 1'b1;
    step(130);
    check("prbs7_active", tx_active, 1);
    tx_data_sel = 1'b0;
    step(2);
    check("prbs7_midword_hold", tx_active, 1);
    step(1);
    check("prbs7_exit_boundary", tx_active, 0);
    check("prbs7_exit_idle_pat", bus.tx_idle_pattern, 1);
    step(3);
    tx_en = 1'b0;
    step(1);
    check("prbs7_sb_drained", sb.size(), 0);

    // PRBS15 with re-seed; prbs_sel changes mid-run are ignored
    m15 = '1;
    for (int i = 0; i < 20; i++) push_bit(prbs15_step(), 1'b0);
    tx_data_sel = 1'b1; prbs_sel = 1'b1; tx_en = 1'b1;
    step(6);
    prbs_sel = 1'b0;
    step(14);
    tx_en = 1'b0;
    step(1);
    check("prbs15_sb_drained", sb.size(), 0);
    tx_prbs_en = 1'b0; tx_data_sel = 1'b0;

    // rst mid-word with three words still queued
    tx_fifo_en = 1'b1;
    for (int i = 0; i < 4; i++) write_word(DATA_W'(i + 5));
    push_word(4'h5, 1'b0, 3);
    tx_en = 1'b1;
    step(3);
    check("rstmid_level", fifo_level, 3);
    rst = 1'b1; tx_en = 1'b0;
    step(1);
    rst = 1'b0;
    check("rstmid_valid", bus.tx_serial_valid, 0);
    check("rstmid_data", bus.tx_serial_data, 0);
    check("rstmid_idle_pat", bus.tx_idle_pattern, 0);
    check("rstmid_active", tx_active, 0);
    check("rstmid_level0", fifo_level, 0);
    check("rstmid_empty", tx_fifo_empty, 1);
    check("rstmid_ready", bus.tx_ready, 1);
    check("rstmid_sb_drained", sb.size(), 0);

    // tx_en drop mid-word keeps FIFO contents
    for (int i = 0; i < 4; i++) write_word(DATA_W'(i + 9));
    push_word(4'h9, 1'b0, 3);
    tx_en = 1'b1;
    step(3);
    tx_en = 1'b0;
    step(1);
    check("endrop_valid", bus.tx_serial_valid, 0);
    check("endrop_active", tx_active, 0);
    check("endrop_level", fifo_level, 3);
    check("endrop_sb_drained", sb.size(), 0);

    // Flush; writes while disabled are ignored
    tx_fifo_en = 1'b0;
    bus.tx_data = 4'h1; bus.tx_valid = 1'b1;
    step(1);
    check("flush_level", fifo_level, 0);
    check("flush_empty", tx_fifo_empty, 1);
    step(1);
    bus.tx_valid = 1'b0;
    check("flush_write_ignored", fifo_level, 0);
    check("flush_no_ovf", tx_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
